bpu_ctrl: RTL

Sequencing controller for the 64-entry branch predictor (2-bit history and target tables). It sweeps-clears the tables after reset and tracks fetch-time predictions in a small in-order FIFO. When ID resolves each instruction, it compares the resolution against the oldest prediction and drives the predictor's single write port plus the IF redirect/flush. It sits between IF (predict side), ID (resolve side) and the predictor tables.

---
 rtl/bpu_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/bpu_ctrl.sv
// Branch predictor sequencing controller: post-reset table sweep, in-order
// prediction FIFO, and resolve-time update/redirect generation.
module bpu_ctrl #(
  parameter int NUM_ENTRIES = 64,
  parameter int IDX_W       = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_fire_i,
  input  logic [31:0]      if_pc_i,
  input  logic             if_pred_taken_i,
  input  logic [31:0]      if_pred_target_i,
  output logic             if_stall_o,
  input  logic             id_valid_i,
  input  logic             id_isJump_i,
  input  logic             id_taken_i,
  input  logic [31:0]      id_target_i,
  output logic             flush_o,
  output logic [31:0]      flush_pc_o,
  output logic             upd_we_o,
  output logic [IDX_W-1:0] upd_idx_o,
  output logic             upd_clear_o,
  output logic             upd_taken_o,
  output logic [31:0]      upd_target_o,
  output logic             init_done_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] SWEEP_END = CNT_W'(NUM_ENTRIES);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;

  logic [31:0] r_fifo_pc     [FIFO_DEPTH];
  logic        r_fifo_ptaken [FIFO_DEPTH];
  logic [31:0] r_fifo_ptgt   [FIFO_DEPTH];

  logic             r_flush;
  logic [31:0]      r_flush_pc;
  logic             r_upd_we;
  logic [IDX_W-1:0] r_upd_idx;
  logic             r_upd_clear;
  logic             r_upd_taken;
  logic [31:0]      r_upd_target;
  logic             r_init_done;

  logic        w_stall;
  logic        w_push;
  logic        w_pop;
  logic        w_sweep_done;
  logic [31:0] w_head_pc;
  logic        w_head_ptaken;
  logic [31:0] w_head_ptgt;
  logic        w_act;
  logic        w_mis;

  assign w_sweep_done  = (r_cnt == SWEEP_END);
  // No full-bypass: a pop in the same cycle does not release a full stall.
  assign w_stall       = (r_state != ST_RUN) | (r_count == FULL_CNT);
  assign w_push        = if_fire_i & ~w_stall;
  assign w_pop         = id_valid_i & (r_state == ST_RUN) & (r_count != '0);

  assign w_head_pc     = r_fifo_pc[r_rd_ptr];
  assign w_head_ptaken = r_fifo_ptaken[r_rd_ptr];
  assign w_head_ptgt   = r_fifo_ptgt[r_rd_ptr];

  assign w_act = id_isJump_i & id_taken_i;
  assign w_mis = (w_head_ptaken ^ w_act) |
                 (w_head_ptaken & w_act & (w_head_ptgt != id_target_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_INIT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      ST_INIT:    if (w_sweep_done) w_state_next = ST_RUN;
      ST_RUN:     if (w_pop && w_mis) w_state_next = ST_RECOVER;
      ST_RECOVER: w_state_next = ST_RUN;
      default:    w_state_next = ST_INIT;
    endcase
  end

  // NOTE: payload storage is not reset; r_count alone decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]     <= if_pc_i;
      r_fifo_ptaken[r_wr_ptr] <= if_pred_taken_i;
      r_fifo_ptgt[r_wr_ptr]   <= if_pred_target_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt        <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_flush      <= 1'b0;
      r_flush_pc   <= '0;
      r_upd_we     <= 1'b0;
      r_upd_idx    <= '0;
      r_upd_clear  <= 1'b0;
      r_upd_taken  <= 1'b0;
      r_upd_target <= '0;
      r_init_done  <= 1'b0;
    end else begin
      r_upd_we <= 1'b0;
      r_flush  <= 1'b0;

      case (r_state)
        ST_INIT: begin
          if (!w_sweep_done) begin
            r_upd_we     <= 1'b1;
            r_upd_idx    <= r_cnt[IDX_W-1:0];
            r_upd_clear  <= 1'b1;
            r_upd_taken  <= 1'b0;
            r_upd_target <= '0;
            r_cnt        <= r_cnt + 1'b1;
          end else begin
            r_init_done <= 1'b1;
          end
        end

        ST_RUN: begin
          if (w_pop) begin
            if (id_isJump_i) begin
              r_upd_we     <= 1'b1;
              r_upd_idx    <= w_head_pc[IDX_W+1:2];
              r_upd_clear  <= 1'b0;
              r_upd_taken  <= id_taken_i;
              r_upd_target <= id_target_i;
            end else if (w_head_ptaken) begin
              // Non-branch predicted taken: the entry aliases, knock it back.
              r_upd_we     <= 1'b1;
              r_upd_idx    <= w_head_pc[IDX_W+1:2];
              r_upd_clear  <= 1'b1;
              r_upd_taken  <= 1'b0;
              r_upd_target <= '0;
            end
            if (w_mis) begin
              r_flush    <= 1'b1;
              r_flush_pc <= w_act ? id_target_i : (w_head_pc + 32'd4);
            end
          end

          if (w_pop && w_mis) begin
            // Flush wins: drop everything in flight, including a same-cycle push.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
          end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
              2'b10:   r_count <= r_count + 1'b1;
              2'b01:   r_count <= r_count - 1'b1;
              default: r_count <= r_count;
            endcase
          end
        end

        default: ;
      endcase
    end
  end

  assign if_stall_o   = w_stall;
  assign flush_o      = r_flush;
  assign flush_pc_o   = r_flush_pc;
  assign upd_we_o     = r_upd_we;
  assign upd_idx_o    = r_upd_idx;
  assign upd_clear_o  = r_upd_clear;
  assign upd_taken_o  = r_upd_taken;
  assign upd_target_o = r_upd_target;
  assign init_done_o  = r_init_done;

endmodule
